tpu_host_driver: RTL

Host-side master for the 2x2 TPU pin interface, driving the TPU's data and control pins and receiving its data and status pins.
- Accepts one matrix-multiply command per valid/ready handshake.
- Serialises the 8 operand bytes onto the TPU data pins with load_en asserted.
- Waits for the TPU done flag, captures the 8 result bytes, and returns four 16-bit results on a valid/ready response port.
- Sits between the test harness/SoC bus and the TPU pins.

---
 rtl/tpu_drv_pkg.sv | 38 +++
 rtl/tpu_result_assembler.sv | 46 ++++
 rtl/tpu_host_driver.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/tpu_drv_pkg.sv
// tpu_drv_pkg
// Shared definitions for the TPU host driver: FSM state encoding, bit
// positions on the TPU control/status pins and byte-count defaults.
// Optional feature macro used by the driver: TPU_DRV_PERF_CNT_EN.
package tpu_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    COLLECT,
    RESP
  } state_t;

  // Control pin bit positions (tpu_ctrl_out)
  localparam int LOAD_EN_BIT   = 0;
  localparam int TRANSPOSE_BIT = 1;
  localparam int ACT_BIT       = 2;
  // Status pin bit position (tpu_status_in)
  localparam int DONE_BIT      = 7;

  // Byte counts per command
  localparam int DEF_NUM_LOAD      = 8;
  localparam int DEF_NUM_RES_BYTES = 8;

  // Compose the control pin word; unused upper bits are always zero.
  function automatic logic [7:0] ctrl_word(input logic load_en,
                                           input logic trans,
                                           input logic act);
    logic [7:0] w;
    w                = '0;
    w[LOAD_EN_BIT]   = load_en;
    w[TRANSPOSE_BIT] = trans;
    w[ACT_BIT]       = act;
    return w;
  endfunction

endpackage

// File: rtl/tpu_result_assembler.sv
// tpu_result_assembler
// Eight-byte capture register for the TPU result stream. The driver FSM
// selects which byte slot to write; clear zeroes every slot (used on new
// commands and on aborts so no stale or partial result is presented).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           zero all captured bytes
//   cap_en, cap_idx write cap_data into byte slot cap_idx
//   cap_data        byte from the TPU data pins
//   c00..c11        16-bit results, {hi byte, lo byte}
module tpu_result_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        cap_en,
  input  logic [2:0]  cap_idx,
  input  logic [7:0]  cap_data,
  output logic [15:0] c00,
  output logic [15:0] c01,
  output logic [15:0] c10,
  output logic [15:0] c11
);

  logic [63:0] bytes_flat;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte
      logic [7:0] b_reg;
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          b_reg <= '0;
        end else if (cap_en && (cap_idx == 3'(gi))) begin
          b_reg <= cap_data;
        end
      end
      assign bytes_flat[gi*8 +: 8] = b_reg;
    end
  endgenerate

  // Stream order is c00 lo, c00 hi, c01 lo, ... so words fall out in order.
  assign c00 = bytes_flat[15:0];
  assign c01 = bytes_flat[31:16];
  assign c10 = bytes_flat[47:32];
  assign c11 = bytes_flat[63:48];

endmodule

// File: rtl/tpu_host_driver.sv
// tpu_host_driver
// Host-side master for the 2x2 TPU pin interface. Accepts one command per
// cmd_valid/cmd_ready handshake, streams 4 weight bytes then 4 input bytes
// with load_en high, waits for the TPU done flag, captures 8 result bytes
// and presents four 16-bit results on a res_valid/res_ready port.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_*                     command handshake and operands
//   tpu_data_out/tpu_ctrl_out TPU input pins (ctrl: [0]load_en [1]transpose [2]activation)
//   tpu_data_in/tpu_status_in TPU output pins (status: [7]done)
//   res_*                     result handshake; res_timeout=1 marks an aborted command
//   busy                      driver not idle
// Optional feature: define TPU_DRV_PERF_CNT_EN to add perf_cycles[15:0],
// the saturating cycle count from command acceptance to first res_valid.
module tpu_host_driver
  import tpu_drv_pkg::*;
#(
  parameter int NUM_LOAD      = DEF_NUM_LOAD,
  parameter int NUM_RES_BYTES = DEF_NUM_RES_BYTES,
  parameter int TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_weights,
  input  logic [31:0] cmd_inputs,
  input  logic        cmd_transpose,
  input  logic        cmd_activation,
  output logic [7:0]  tpu_data_out,
  output logic [7:0]  tpu_ctrl_out,
  input  logic [7:0]  tpu_data_in,
  input  logic [7:0]  tpu_status_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_c00,
  output logic [15:0] res_c01,
  output logic [15:0] res_c10,
  output logic [15:0] res_c11,
  output logic        res_timeout,
  output logic        busy
`ifdef TPU_DRV_PERF_CNT_EN
  ,
  output logic [15:0] perf_cycles
`endif
);

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [63:0] operands_reg, operands_next;
  logic        trans_reg, trans_next;
  logic        act_reg, act_next;
  logic        cmd_ready_reg, cmd_ready_next;
  logic        busy_reg, busy_next;
  logic        res_valid_reg, res_valid_next;
  logic        res_timeout_reg, res_timeout_next;
  logic [7:0]  data_out_reg, data_out_next;
  logic [7:0]  ctrl_out_reg, ctrl_out_next;
  logic        abort_next;
  logic        accept;
  logic        cap_en;
  logic [2:0]  cap_idx;
  logic        asm_clear;
  logic        done;

  assign done = tpu_status_in[DONE_BIT];

  // Only the done flag matters to the driver; the other status bits are ignored.
  logic status_unused;
  assign status_unused = &{1'b0, tpu_status_in[6:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      wait_cnt_reg    <= '0;
      operands_reg    <= '0;
      trans_reg       <= 1'b0;
      act_reg         <= 1'b0;
      cmd_ready_reg   <= 1'b1;
      busy_reg        <= 1'b0;
      res_valid_reg   <= 1'b0;
      res_timeout_reg <= 1'b0;
      data_out_reg    <= '0;
      ctrl_out_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      wait_cnt_reg    <= wait_cnt_next;
      operands_reg    <= operands_next;
      trans_reg       <= trans_next;
      act_reg         <= act_next;
      cmd_ready_reg   <= cmd_ready_next;
      busy_reg        <= busy_next;
      res_valid_reg   <= res_valid_next;
      res_timeout_reg <= res_timeout_next;
      data_out_reg    <= data_out_next;
      ctrl_out_reg    <= ctrl_out_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    wait_cnt_next = wait_cnt_reg;
    abort_next    = res_timeout_reg;
    accept        = 1'b0;
    cap_en        = 1'b0;
    cap_idx       = idx_reg;
    asm_clear     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          accept     = 1'b1;
          asm_clear  = 1'b1;
          idx_next   = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (idx_reg == 3'(NUM_LOAD - 1)) begin
          idx_next      = '0;
          wait_cnt_next = '0;
          state_next    = WAIT_DONE;
        end else begin
          idx_next = idx_reg + 3'd1;
        end
      end
      WAIT_DONE: begin
        // The byte on the pins in the cycle done is first seen is byte 0.
        if (done) begin
          cap_en     = 1'b1;
          cap_idx    = '0;
          idx_next   = 3'd1;
          state_next = COLLECT;
        end else if (wait_cnt_reg == 8'(TIMEOUT - 1)) begin
          abort_next = 1'b1;
          asm_clear  = 1'b1;
          state_next = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      COLLECT: begin
        if (done) begin
          cap_en = 1'b1;
          if (idx_reg == 3'(NUM_RES_BYTES - 1)) begin
            state_next = RESP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          // Done fell early: discard the partial result.
          abort_next = 1'b1;
          asm_clear  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    operands_next = accept ? {cmd_inputs, cmd_weights} : operands_reg;
    trans_next    = accept ? cmd_transpose : trans_reg;
    act_next      = accept ? cmd_activation : act_reg;

    // Outputs are registered from the next state so they line up with it.
    cmd_ready_next   = (state_next == IDLE);
    busy_next        = (state_next != IDLE);
    res_valid_next   = (state_next == RESP);
    res_timeout_next = (state_next == RESP) ? abort_next : 1'b0;
    data_out_next    = (state_next == LOAD) ? operands_next[{idx_next, 3'b000} +: 8] : 8'd0;
    ctrl_out_next    = (state_next == IDLE) ? 8'd0
                     : ctrl_word(state_next == LOAD, trans_next, act_next);
  end

  tpu_result_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (asm_clear),
    .cap_en   (cap_en),
    .cap_idx  (cap_idx),
    .cap_data (tpu_data_in),
    .c00      (res_c00),
    .c01      (res_c01),
    .c10      (res_c10),
    .c11      (res_c11)
  );

  assign cmd_ready    = cmd_ready_reg;
  assign busy         = busy_reg;
  assign res_valid    = res_valid_reg;
  assign res_timeout  = res_timeout_reg;
  assign tpu_data_out = data_out_reg;
  assign tpu_ctrl_out = ctrl_out_reg;

`ifdef TPU_DRV_PERF_CNT_EN
  logic [15:0] perf_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_reg <= '0;
    end else if (accept) begin
      perf_reg <= '0;
    end else if ((state_reg == LOAD || state_reg == WAIT_DONE || state_reg == COLLECT)
                 && (perf_reg != 16'hFFFF)) begin
      perf_reg <= perf_reg + 16'd1;
    end
  end
  assign perf_cycles = perf_reg;
`endif

endmodule
